// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-channel debouncer with one shared lockout timer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE  = 2'd0,
        PENDING = 2'd1,
        TIMING  = 2'd2
    } ch_state_t;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_t;

    localparam int DEFAULT_NUM_CH        = 4;
    localparam int DEFAULT_COUNTER_WIDTH = 21;
    localparam int DEFAULT_TIMER_VALUE   = 2_000_000;

    // Index that follows idx when walking n slots cyclically.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after the last granted index, wrapping.
// The last-granted pointer is held here and reloaded when a timer slot ends.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 last_we,
    input  logic [$clog2(N)-1:0] last,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] idx_s;

    // Pointer reset to N-1 so that channel 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= IW'(N - 1);
        end else if (last_we) begin
            ptr_q <= last;
        end else begin
            ptr_q <= ptr_q;
        end
    end

    // Combinational search starting just after the pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx_s     = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx_s = IW'(rr_next(int'(idx_s), N));
            if (!gnt_valid && req[idx_s]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx_s;
            end else begin
                gnt_valid = gnt_valid;
            end
        end
    end

endmodule

// File: rtl/debounce_timer_arbiter.sv
// Early-detection debouncer: each channel follows its first edge immediately, then stays frozen
// until it has held the single shared lockout timer for TIMER_VALUE cycles.
module debounce_timer_arbiter
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = DEFAULT_NUM_CH,
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int TIMER_VALUE   = DEFAULT_TIMER_VALUE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         in,
    output logic [NUM_CH-1:0]         out,
    output logic [NUM_CH-1:0]         lock,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] grant_id
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(TIMER_VALUE - 1);

    timer_state_t             timer_q;
    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_d;
    logic [IW-1:0]            grant_id_q;
    logic                     busy_q;

    logic [NUM_CH-1:0] pending_s;
    logic              gnt_valid_s;
    logic [IW-1:0]     gnt_id_s;
    logic              start_s;
    logic              expire_s;

    assign counter_d = counter_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    assign start_s   = (timer_q == T_IDLE) && gnt_valid_s;
    assign expire_s  = (timer_q == T_RUN) && (counter_q == CNT_LAST);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (pending_s),
        .last_we   (expire_s),
        .last      (grant_id_q),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic      s1_q;
        logic      s2_q;
        logic      out_q;
        logic      lock_q;
        ch_state_t state_q;

        // Synchronizer plus channel lockout FSM; edges seen while locked are dropped.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                out_q   <= 1'b0;
                lock_q  <= 1'b0;
                state_q <= STABLE;
            end else begin
                s1_q <= in[g];
                s2_q <= s1_q;
                case (state_q)
                    STABLE: begin
                        if (s2_q != out_q) begin
                            out_q   <= ~out_q;
                            lock_q  <= 1'b1;
                            state_q <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (start_s && (gnt_id_s == IW'(g))) begin
                            state_q <= TIMING;
                        end
                    end
                    TIMING: begin
                        if (expire_s && (grant_id_q == IW'(g))) begin
                            lock_q  <= 1'b0;
                            state_q <= STABLE;
                        end
                    end
                    default: begin
                        lock_q  <= 1'b0;
                        state_q <= STABLE;
                    end
                endcase
            end
        end

        assign pending_s[g] = (state_q == PENDING);
        assign out[g]       = out_q;
        assign lock[g]      = lock_q;
    end

    // Shared timer: grant only from IDLE, so one idle cycle always separates two grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q    <= T_IDLE;
            counter_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (timer_q)
                T_IDLE: begin
                    if (start_s) begin
                        grant_id_q <= gnt_id_s;
                        counter_q  <= '0;
                        busy_q     <= 1'b1;
                        timer_q    <= T_RUN;
                    end
                end
                T_RUN: begin
                    if (expire_s) begin
                        counter_q <= '0;
                        busy_q    <= 1'b0;
                        timer_q   <= T_IDLE;
                    end else begin
                        counter_q <= counter_d;
                    end
                end
                default: begin
                    counter_q <= '0;
                    busy_q    <= 1'b0;
                    timer_q   <= T_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Bench: cycle model of the debouncer rules checked every cycle, plus directed literal checks.
module tb_debounce_timer_arbiter;

    localparam int N  = 4;
    localparam int TV = 8;
    localparam int CW = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] in_v    = '0;
    logic [N-1:0] out_w;
    logic [N-1:0] lock_w;
    logic         busy_w;
    logic [1:0]   gid_w;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    debounce_timer_arbiter #(.NUM_CH(N), .COUNTER_WIDTH(CW), .TIMER_VALUE(TV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in_v),
        .out      (out_w),
        .lock     (lock_w),
        .busy     (busy_w),
        .grant_id (gid_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model: sync delay, toggle-and-lock, FIFO-free round robin over waiting channels,
    // owner holds the timer for TV edges then releases.
    logic [N-1:0] m_s1, m_s2, m_out, m_lock, m_wait;
    logic [N-1:0] o_lock, o_s2, o_wait;
    int m_owner, m_left, m_ptr, c;
    bit found;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_lock = '0; m_wait = '0;
            m_owner = -1; m_left = 0; m_ptr = N - 1;
        end else begin
            o_lock = m_lock; o_s2 = m_s2; o_wait = m_wait;
            if (m_owner >= 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_lock[m_owner] = 1'b0;
                    m_ptr = m_owner;
                    m_owner = -1;
                end
            end else begin
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!found && o_wait[c]) begin
                        found = 1'b1;
                        m_wait[c] = 1'b0;
                        m_owner = c;
                        m_left = TV;
                    end
                end
            end
            for (int ch = 0; ch < N; ch++) begin
                if (!o_lock[ch] && (o_s2[ch] != m_out[ch])) begin
                    m_out[ch]  = ~m_out[ch];
                    m_lock[ch] = 1'b1;
                    m_wait[ch] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = in_v;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out", 32'(out_w), 32'(m_out));
            check("model_lock", 32'(lock_w), 32'(m_lock));
            check("model_busy", 32'(busy_w), 32'(m_owner >= 0));
            if (m_owner >= 0) check("model_grant_id", 32'(gid_w), 32'(m_owner));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_v    = '0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic wait_busy(input logic lvl, input int bound);
        int n;
        n = 0;
        while (busy_w !== lvl && n < bound) begin
            step(1);
            n++;
        end
        if (busy_w !== lvl) check("wait_busy_timeout", 32'(busy_w), 32'(lvl));
    endtask

    task automatic busy_len(output int n);
        n = (busy_w === 1'b1) ? 1 : 0;
        while (busy_w === 1'b1 && n < 20) begin
            step(1);
            if (busy_w === 1'b1) n++;
        end
    endtask

    int n;
    int last_gid, last_cyc, cyc;
    bit prev_busy, have_prev;

    initial begin
        step(2);
        check("reset_out", 32'(out_w), 32'h0);
        check("reset_lock", 32'(lock_w), 32'h0);
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_gid", 32'(gid_w), 32'h0);
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        step(1);

        // 1: bouncing rise on ch0
        in_v[0] = 1'b1; step(1);
        in_v[0] = 1'b0; step(1);
        check("t1_out_before_e2", 32'(out_w[0]), 32'h0);
        in_v[0] = 1'b1; step(1);
        check("t1_out_e2", 32'(out_w[0]), 32'h1);
        in_v[0] = 1'b0; step(1);
        check("t1_busy_e3", 32'(busy_w), 32'h1);
        check("t1_gid", 32'(gid_w), 32'h0);
        in_v[0] = 1'b1;
        busy_len(n);
        check("t1_busy_len", 32'(n), 32'(TV));
        check("t1_unlock", 32'(lock_w[0]), 32'h0);
        step(3);
        check("t1_out_hold", 32'(out_w[0]), 32'h1);
        check("t1_idle", 32'(busy_w), 32'h0);

        // 2: simultaneous rise on ch1, ch2
        do_reset();
        in_v[2:1] = 2'b11;
        step(3);
        check("t2_outs", 32'(out_w), 32'h6);
        step(1);
        check("t2_gid1", 32'(gid_w), 32'h1);
        check("t2_lock", 32'(lock_w), 32'h6);
        step(8);
        check("t2_gap_busy", 32'(busy_w), 32'h0);
        check("t2_lock2_wait", 32'(lock_w), 32'h4);
        step(1);
        check("t2_busy2", 32'(busy_w), 32'h1);
        check("t2_gid2", 32'(gid_w), 32'h2);
        step(8);
        check("t2_done", 32'(lock_w), 32'h0);

        // 3: round-robin wrap after ch0
        do_reset();
        in_v[0] = 1'b1;
        step(4);
        check("t3_gid0", 32'(gid_w), 32'h0);
        step(2);
        in_v[3] = 1'b1; in_v[1] = 1'b1;
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 5);
        check("t3_first_ch1", 32'(gid_w), 32'h1);
        check("t3_ch3_locked", 32'(lock_w[3]), 32'h1);
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 5);
        check("t3_then_ch3", 32'(gid_w), 32'h3);

        // 4: level mismatch at release
        do_reset();
        in_v[0] = 1'b1; step(2);
        in_v[0] = 1'b0; step(1);
        check("t4_out_e2", 32'(out_w[0]), 32'h1);
        step(9);
        check("t4_release_out", 32'(out_w[0]), 32'h1);
        check("t4_release_lock", 32'(lock_w[0]), 32'h0);
        step(1);
        check("t4_out_fall", 32'(out_w[0]), 32'h0);
        check("t4_relock", 32'(lock_w[0]), 32'h1);
        step(1);
        check("t4_regrant", 32'(busy_w), 32'h1);

        // 5: reset in the middle of a run
        do_reset();
        in_v[0] = 1'b1;
        step(8);
        #2 reset_n = 1'b0; in_v = '0;
        #1;
        check("t5_out_rst", 32'(out_w), 32'h0);
        check("t5_lock_rst", 32'(lock_w), 32'h0);
        check("t5_busy_rst", 32'(busy_w), 32'h0);
        step(2);
        reset_n = 1'b1;
        step(1);
        in_v[2] = 1'b1;
        step(4);
        check("t5_gid2", 32'(gid_w), 32'h2);
        busy_len(n);
        check("t5_busy_len", 32'(n), 32'(TV));

        // 6: all channels toggling: strict rotation, one grant every TV+1 cycles
        do_reset();
        prev_busy = 1'b0; have_prev = 1'b0; last_gid = 0; last_cyc = 0;
        for (cyc = 0; cyc < 300; cyc++) begin
            in_v = ~in_v;
            step(1);
            if (busy_w && !prev_busy) begin
                if (have_prev) begin
                    check("t6_rotation", 32'(gid_w), 32'((last_gid + 1) % N));
                    check("t6_spacing", 32'(cyc - last_cyc), 32'(TV + 1));
                end
                have_prev = 1'b1;
                last_gid = int'(gid_w);
                last_cyc = cyc;
            end
            prev_busy = busy_w;
        end
        check("t6_grants_seen", 32'(have_prev), 32'h1);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
